// File: rtl/poets_stream_pkt_buffer_if.sv
// Avalon-ST beat bundle shared by the packet buffer sink and source sides.
// The producer of a stream uses the master modport and the consumer uses the slave modport.
`timescale 1ns/1ps
interface poets_stream_pkt_buffer_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2
);
  logic               valid;
  logic [DATA_W-1:0]  data;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               ready;

  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/poets_stream_pkt_buffer.sv
// Store-and-forward Avalon-ST packet buffer: only complete, well-formed packets reach the source.
// Oversized, truncated and orphan traffic is discarded and counted in drop_count.
`timescale 1ns/1ps
module poets_stream_pkt_buffer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned EMPTY_W  = 2,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_PKTS = 8,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned PCW     = $clog2(MAX_PKTS) + 1,
  localparam int unsigned WW      = 1 + EMPTY_W + DATA_W
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  poets_stream_pkt_buffer_if.slave  snk,
  poets_stream_pkt_buffer_if.master src,
  output logic [PCW-1:0]            pkt_count,
  output logic [15:0]               drop_count
);

  typedef enum logic [1:0] {StIdle, StFill, StDrop} st_e;

  st_e            st_q, st_d;
  logic [AW:0]    wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic [AW:0]    base, used, free;
  logic [PCW-1:0] pc_q, pc_d;
  logic [15:0]    drop_q;
  logic           first_q, first_d;
  logic           snk_fire, oversize, we, commit, drop_evt;
  logic           pop, pop_eop;
  logic [WW-1:0]  mem [DEPTH];
  logic [WW-1:0]  rd_word;

  // Pointers carry one extra bit so a completely full buffer is distinguishable from empty.
  assign used     = wr_q - rd_q;
  assign free     = (AW + 1)'(DEPTH) - used;
  assign oversize = (free == '0) && (pc_q == '0);
  assign snk.ready = (st_q == StDrop) ||
                     ((pc_q < PCW'(MAX_PKTS)) && ((free != '0) || (pc_q == '0)));
  assign snk_fire = snk.valid & snk.ready;

  always_comb begin
    st_d     = st_q;
    wr_d     = wr_q;
    cm_d     = cm_q;
    base     = wr_q;
    we       = 1'b0;
    commit   = 1'b0;
    drop_evt = 1'b0;
    if (snk_fire) begin
      if ((st_q != StDrop) && oversize) begin
        wr_d     = cm_q;
        drop_evt = 1'b1;
        st_d     = snk.eop ? StIdle : StDrop;
      end else begin
        case (st_q)
          StIdle, StFill: begin
            if ((st_q == StIdle) && !snk.sop) begin
              drop_evt = 1'b1;
            end else begin
              // A sop while filling abandons the partial packet and restarts at the commit point.
              if ((st_q == StFill) && snk.sop) begin
                base     = cm_q;
                drop_evt = 1'b1;
              end
              we   = 1'b1;
              wr_d = base + 1'b1;
              if (snk.eop) begin
                commit = 1'b1;
                cm_d   = base + 1'b1;
                st_d   = StIdle;
              end else begin
                st_d   = StFill;
              end
            end
          end
          StDrop:  if (snk.eop) st_d = StIdle;
          default: st_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (we) mem[base[AW-1:0]] <= {snk.eop, snk.empty, snk.data};
  end

  assign rd_word = mem[rd_q[AW-1:0]];
  assign pop     = src.valid & src.ready;
  assign pop_eop = pop & rd_word[WW-1];
  assign rd_d    = pop ? rd_q + 1'b1 : rd_q;
  assign first_d = pop ? rd_word[WW-1] : first_q;

  always_comb begin
    pc_d = pc_q;
    if (commit && !pop_eop) pc_d = pc_q + 1'b1;
    else if (!commit && pop_eop) pc_d = pc_q - 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      st_q    <= StIdle;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      drop_q  <= '0;
      first_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      first_q <= first_d;
      if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Source fields are forced to zero when idle so reset shows no stale memory contents.
  assign src.valid  = (pc_q != '0);
  assign src.data   = src.valid ? rd_word[DATA_W-1:0] : '0;
  assign src.eop    = src.valid & rd_word[WW-1];
  assign src.empty  = src.eop ? rd_word[WW-2 -: EMPTY_W] : '0;
  assign src.sop    = src.valid & first_q;
  assign pkt_count  = pc_q;
  assign drop_count = drop_q;

endmodule
